vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Drives the VGA raster. Generates HSYNC/VSYNC and the scaled pixel coordinates X/Y
//  that feed the per-pixel colour blocks (background, bird, pipes). Registers their
//  3-bit RGB answer back into RGB_OUT, aligned with the sync outputs, for the DAC pins.
//  Native 640x480@60 timing. Each logical pixel is repeated 2x2, giving a 320x240 grid
//  addressed by X[8:0] and Y[7:0].
// PARAMETERS
//  H_VISIBLE    640  visible pixel clocks per line
//  H_FRONT      16   horizontal front porch
//  H_SYNC       96   HSYNC pulse width
//  H_BACK       48   horizontal back porch (H_TOTAL = 800)
//  V_VISIBLE    480  visible lines per frame
//  V_FRONT      10   vertical front porch
//  V_SYNC       2    VSYNC pulse width, in lines
//  V_BACK       33   vertical back porch (V_TOTAL = 525)
//  SCALE_SHIFT  1    coordinate right-shift (native -> logical pixel)
// PORTS
//  CLK          in   1   system clock
//  RST_N        in   1   asynchronous active-low reset
//  PIX_EN       in   1   pixel-clock enable: one raster step per CLK with PIX_EN=1
//  RGB_IN       in   3   colour from the pixel blocks for the current X/Y
//  X            out  9   logical column 0..319; 0 while blanked
//  Y            out  8   logical row 0..239; 0 while blanked
//  ACTIVE       out  1   1 while X/Y are inside the visible area
//  HSYNC        out  1   horizontal sync, active low
//  VSYNC        out  1   vertical sync, active low
//  RGB_OUT      out  3   registered pixel colour; 3'b000 during blanking
//  FRAME_START  out  1   one-CLK pulse when the raster wraps to (0,0)
// BEHAVIOUR
//  - One clock domain (CLK); reset is asynchronous, active-low on RST_N.
//  - Reset values (applied immediately, also mid-frame): H_CNT=0, V_CNT=0, X=0, Y=0,
//    ACTIVE=0, HSYNC=1, VSYNC=1, RGB_OUT=0, FRAME_START=0. The first step after
//    release produces pixel (0,0).
//  - PIX_EN=0: all state and outputs hold, except FRAME_START, which returns to 0.
//  - On each PIX_EN step:
//    - H_CNT (10b) increments and wraps at H_TOTAL-1 -> 0.
//    - V_CNT (10b) increments only on the H wrap, and wraps at V_TOTAL-1 -> 0.
//  - Axis phase FSM, per axis: VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE.
//    - Transitions occur when the counter reaches the end of the current phase.
//    - Sync is asserted (low) only in the SYNC phase.
//  - Stage 1, registered from the counters:
//    - ACTIVE = hVISIBLE & vVISIBLE.
//    - X = H_CNT>>SCALE_SHIFT and Y = V_CNT>>SCALE_SHIFT; both forced to 0 when !ACTIVE.
//  - Stage 2, one PIX_EN step later:
//    - RGB_OUT = ACTIVE_d ? RGB_IN : 3'b000.
//    - HSYNC/VSYNC are delayed by the same amount, so sync and colour stay aligned.
//    - Latency from X/Y to RGB_OUT is exactly one PIX_EN step.
//  - RGB_IN is sampled combinationally from X/Y. The pixel blocks must settle within
//    one CLK.
//  - FRAME_START = 1 for exactly the CLK in which H_CNT and V_CNT both wrap to 0.
//  - HSYNC low for native H_CNT 656..751; VSYNC low for V_CNT 490..491.
// CONFIGURATION
//  VGA_PIX_DIV_EN defined:
//    - PIX_EN is ignored.
//    - An internal toggle flop (reset to 0) produces an enable on every 2nd CLK
//      (50 MHz CLK -> 25 MHz raster).
//  VGA_PIX_DIV_EN undefined:
//    - PIX_EN is used directly; there is no divider flop.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//    - the default timing constants and H_TOTAL/V_TOTAL;
//    - the counter width (10);
//    - the 2-bit phase encoding: VISIBLE=0, FRONT=1, SYNC=2, BACK=3.
//  - Sub-module vga_axis_counter holds one counter, its phase FSM and its wrap flag.
//    It is instantiated twice:
//    - horizontal: step = PIX_EN;
//    - vertical: step = PIX_EN & h_wrap.
// TESTING
//  - Reset then run one line:
//    - all outputs hold their reset values while RST_N=0;
//    - HSYNC goes low at step 656 for exactly 96 steps; the line period is 800 steps.
//  - Full frame:
//    - VSYNC is low for 2 lines (1600 steps) starting at line 490;
//    - FRAME_START pulses once every 420000 steps.
//  - Coordinate mapping: H_CNT=3, V_CNT=461 -> X=1, Y=230, ACTIVE=1.
//    With RGB_IN=3'b001, RGB_OUT=3'b001 on the next step.
//  - Blanking: RGB_IN=3'b111 held while H_CNT=700 -> RGB_OUT=0, X=0, Y=0, ACTIVE=0.
//  - Stall and reset:
//    - PIX_EN=0 for 10 CLKs mid-line -> outputs frozen;
//    - RST_N=0 at H_CNT=300 -> outputs reach reset values immediately, without a
//      CLK edge.
//  - VGA_PIX_DIV_EN defined: with PIX_EN tied 0, a full line takes 1600 CLKs and
//    HSYNC is low for 192 CLKs.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster generator.
//   - default 640x480@60 timing and the derived line/frame totals
//   - raster counter width
//   - per-axis phase encoding (VISIBLE=0, FRONT=1, SYNC=2, BACK=3)
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int H_TOTAL       = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int V_TOTAL       = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_SCALE_SHIFT = 1;

  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, phase FSM and wrap flag.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   step       : advance one position this clock
//   cnt        : current position 0..TOTAL-1
//   phase      : phase of the current position
//   wrap       : step is taking cnt from TOTAL-1 back to 0 (combinational)
//
// state      | meaning
// PH_VISIBLE | cnt in 0 .. VISIBLE-1
// PH_FRONT   | cnt in the front porch
// PH_SYNC    | cnt in the sync pulse (sync output asserted)
// PH_BACK    | cnt in the back porch, up to TOTAL-1
import vga_timing_pkg::*;

module vga_axis_counter #(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output phase_t           phase,
  output logic             wrap
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CNT_W-1:0] END_VIS   = CNT_W'(VISIBLE - 1);
  localparam logic [CNT_W-1:0] END_FRONT = CNT_W'(VISIBLE + FRONT - 1);
  localparam logic [CNT_W-1:0] END_SYNC  = CNT_W'(VISIBLE + FRONT + SYNC - 1);
  localparam logic [CNT_W-1:0] END_TOTAL = CNT_W'(TOTAL - 1);

  phase_t phase_d;

  assign wrap = step && (cnt == END_TOTAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= PH_VISIBLE;
    end else begin
      phase <= phase_d;
      if (step) cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  // Phase moves together with cnt, so it always describes the current position.
  always_comb begin
    phase_d = phase;
    if (step) begin
      unique case (phase)
        PH_VISIBLE: if (cnt == END_VIS)   phase_d = PH_FRONT;
        PH_FRONT:   if (cnt == END_FRONT) phase_d = PH_SYNC;
        PH_SYNC:    if (cnt == END_SYNC)  phase_d = PH_BACK;
        PH_BACK:    if (cnt == END_TOTAL) phase_d = PH_VISIBLE;
        default:    phase_d = PH_VISIBLE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with 2x2 pixel scaling and a registered
// colour return path aligned to the sync outputs.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   pix_en      : raster step enable (ignored when VGA_PIX_DIV_EN is defined)
//   rgb_in[2:0] : colour from the pixel blocks for the current x/y
//   x[8:0]      : logical column, 0 while blanked
//   y[7:0]      : logical row, 0 while blanked
//   active      : x/y lie in the visible area
//   hsync/vsync : active-low syncs, aligned with rgb_out
//   rgb_out     : registered colour, 0 during blanking
//   frame_start : one-clock pulse when the raster wraps to (0,0)
// Build option: VGA_PIX_DIV_EN -- derive the step from an internal divide-by-2
// toggle instead of pix_en.
import vga_timing_pkg::*;

module vga_timing_gen #(
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [2:0] rgb_in,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out,
  output logic       frame_start
);

  logic             step;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  phase_t           h_phase, v_phase;
  logic             h_wrap, v_wrap;
  logic             vis;
  logic [CNT_W-1:0] h_scaled, v_scaled;
  logic             hsync_s1, vsync_s1;
  logic             unused_bits;

`ifdef VGA_PIX_DIV_EN
  logic div_q;
  logic unused_pix_en;

  assign unused_pix_en = pix_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= 1'b0;
    else        div_q <= ~div_q;
  end

  assign step = div_q;
`else
  assign step = pix_en;
`endif

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(step),
    .cnt(h_cnt), .phase(h_phase), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(step & h_wrap),
    .cnt(v_cnt), .phase(v_phase), .wrap(v_wrap)
  );

  assign vis         = (h_phase == PH_VISIBLE) && (v_phase == PH_VISIBLE);
  assign h_scaled    = h_cnt >> SCALE_SHIFT;
  assign v_scaled    = v_cnt >> SCALE_SHIFT;
  assign unused_bits = ^{h_scaled[CNT_W-1:9], v_scaled[CNT_W-1:8]};

  // Stage 1 registers coordinates/active and sync; stage 2 registers the colour
  // returned for those coordinates and re-delays sync so both leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      hsync_s1    <= 1'b1;
      vsync_s1    <= 1'b1;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb_out     <= 3'b000;
      frame_start <= 1'b0;
    end else begin
      frame_start <= h_wrap & v_wrap;
      if (step) begin
        active   <= vis;
        x        <= vis ? h_scaled[8:0] : '0;
        y        <= vis ? v_scaled[7:0] : '0;
        hsync_s1 <= (h_phase != PH_SYNC);
        vsync_s1 <= (v_phase != PH_SYNC);
        rgb_out  <= active ? rgb_in : 3'b000;
        hsync    <= hsync_s1;
        vsync    <= vsync_s1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_n;
  logic       pix_en;
  logic [2:0] rgb_in;

  logic [8:0] a_x;
  logic [7:0] a_y;
  logic       a_active, a_hsync, a_vsync, a_frame_start;
  logic [2:0] a_rgb_out;

  logic [8:0] b_x;
  logic [7:0] b_y;
  logic       b_active, b_hsync, b_vsync, b_frame_start;
  logic [2:0] b_rgb_out;

  int tests;
  int fails;
  int k;

  // Instance a: native 640x480 timing.
  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .rgb_in(rgb_in),
    .x(a_x), .y(a_y), .active(a_active), .hsync(a_hsync), .vsync(a_vsync),
    .rgb_out(a_rgb_out), .frame_start(a_frame_start)
  );

  // Instance b: 16-step lines with native vertical timing, so a whole frame
  // (and line 461) is reachable in a short run.
  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(4), .H_BACK(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .rgb_in(rgb_in),
    .x(b_x), .y(b_y), .active(b_active), .hsync(b_hsync), .vsync(b_vsync),
    .rgb_out(b_rgb_out), .frame_start(b_frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         k;
    logic [2:0] rgb;
    logic [8:0] x;
    logic [7:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic [2:0] rgbo;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", name, act, exp, k);
    end
  endtask

  function automatic logic [31:0] pack_a();
    return {8'd0, a_x, a_y, a_active, a_hsync, a_vsync, a_rgb_out, a_frame_start};
  endfunction

  function automatic logic [31:0] pack_b();
    return {8'd0, b_x, b_y, b_active, b_hsync, b_vsync, b_rgb_out, b_frame_start};
  endfunction

  function automatic logic [31:0] pack_exp(input logic [8:0] ex, input logic [7:0] ey,
                                           input logic eact, input logic ehs, input logic evs,
                                           input logic [2:0] ergb, input logic efs);
    return {8'd0, ex, ey, eact, ehs, evs, ergb, efs};
  endfunction

  // Step continuously (pix_en=1) until k steps have been taken since release.
  task automatic run_to(input int target);
    pix_en = 1'b1;
    while (k < target) begin
      @(negedge clk);
      k++;
    end
    pix_en = 1'b0;
  endtask

  initial begin
    int a_fall1, a_rise1, a_fall2;
    int b_vfall, b_vrise, fs_cnt, fs1, fs2;
    logic prev_a_hs, prev_b_vs;
    logic [31:0] reset_val;

    tests = 0; fails = 0; k = 0;
    rst_n  = 1'b0;
    pix_en = 1'b1;
    rgb_in = 3'b111;
    reset_val = pack_exp(9'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0);

    repeat (4) @(negedge clk);
    chk("reset_hold_a", pack_a(), reset_val);
    chk("reset_hold_b", pack_b(), reset_val);

`ifdef VGA_PIX_DIV_EN
    // pix_en tied low; the internal divider alone drives the raster.
    pix_en  = 1'b0;
    rst_n   = 1'b1;
    a_fall1 = -1; a_rise1 = -1; a_fall2 = -1;
    prev_a_hs = 1'b1;
    for (int c = 1; c <= 3200; c++) begin
      @(negedge clk);
      if (prev_a_hs && !a_hsync) begin
        if (a_fall1 < 0) a_fall1 = c;
        else if (a_fall2 < 0) a_fall2 = c;
      end
      if (!prev_a_hs && a_hsync && a_rise1 < 0) a_rise1 = c;
      prev_a_hs = a_hsync;
    end
    chk("div_hsync_first_fall", a_fall1, 1316);
    chk("div_line_period", a_fall2 - a_fall1, 1600);
    chk("div_hsync_width", a_rise1 - a_fall1, 192);
`else
    // k=n: n steps taken. Stage 1 shows counter position n-1, stage 2
    // (colour/sync) shows position n-2.
    vecs[0]  = '{1,    3'b101, 9'd0,   8'd0, 1'b1, 1'b1, 1'b1, 3'b000};
    vecs[1]  = '{2,    3'b101, 9'd0,   8'd0, 1'b1, 1'b1, 1'b1, 3'b101};
    vecs[2]  = '{8,    3'b011, 9'd3,   8'd0, 1'b1, 1'b1, 1'b1, 3'b011};
    vecs[3]  = '{640,  3'b110, 9'd319, 8'd0, 1'b1, 1'b1, 1'b1, 3'b110};
    vecs[4]  = '{641,  3'b111, 9'd0,   8'd0, 1'b0, 1'b1, 1'b1, 3'b111};
    vecs[5]  = '{642,  3'b111, 9'd0,   8'd0, 1'b0, 1'b1, 1'b1, 3'b000};
    vecs[6]  = '{657,  3'b010, 9'd0,   8'd0, 1'b0, 1'b1, 1'b1, 3'b000};
    vecs[7]  = '{658,  3'b010, 9'd0,   8'd0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[8]  = '{701,  3'b111, 9'd0,   8'd0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[9]  = '{753,  3'b111, 9'd0,   8'd0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[10] = '{754,  3'b111, 9'd0,   8'd0, 1'b0, 1'b1, 1'b1, 3'b000};
    vecs[11] = '{801,  3'b100, 9'd0,   8'd0, 1'b1, 1'b1, 1'b1, 3'b000};
    vecs[12] = '{802,  3'b100, 9'd0,   8'd0, 1'b1, 1'b1, 1'b1, 3'b100};
    vecs[13] = '{803,  3'b100, 9'd1,   8'd0, 1'b1, 1'b1, 1'b1, 3'b100};
    vecs[14] = '{1603, 3'b001, 9'd1,   8'd1, 1'b1, 1'b1, 1'b1, 3'b001};

    pix_en = 1'b0;
    rst_n  = 1'b1;
    k      = 0;

    foreach (vecs[i]) begin
      rgb_in = vecs[i].rgb;
      run_to(vecs[i].k);
      chk($sformatf("vec%0d", i), pack_a(),
          pack_exp(vecs[i].x, vecs[i].y, vecs[i].act, vecs[i].hs, vecs[i].vs, vecs[i].rgbo, 1'b0));
    end

    // Stall mid-line: position 1609 (h=9, v=2) on stage 1.
    rgb_in = 3'b010;
    run_to(1610);
    chk("pre_stall", pack_a(), pack_exp(9'd4, 8'd1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0));
    rgb_in = 3'b101;
    repeat (10) @(negedge clk);
    chk("stall_frozen", pack_a(), pack_exp(9'd4, 8'd1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0));

    // Counter at h=300 on line 2, then async reset between clock edges.
    rgb_in = 3'b011;
    run_to(1900);
    chk("pre_reset", pack_a(), pack_exp(9'd149, 8'd1, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_a", pack_a(), reset_val);
    chk("async_reset_b", pack_b(), reset_val);
    @(negedge clk);

    // Continuous run from release: line timing on a, frame timing and
    // coordinate mapping on b.
    rgb_in  = 3'b110;
    rst_n   = 1'b1;
    pix_en  = 1'b1;
    k       = 0;
    a_fall1 = -1; a_rise1 = -1; a_fall2 = -1;
    b_vfall = -1; b_vrise = -1;
    fs_cnt  = 0; fs1 = -1; fs2 = -1;
    prev_a_hs = 1'b1;
    prev_b_vs = 1'b1;
    while (k < 16805) begin
      @(negedge clk);
      k++;
      if (prev_a_hs && !a_hsync) begin
        if (a_fall1 < 0) a_fall1 = k;
        else if (a_fall2 < 0) a_fall2 = k;
      end
      if (!prev_a_hs && a_hsync && a_rise1 < 0) a_rise1 = k;
      prev_a_hs = a_hsync;
      if (prev_b_vs && !b_vsync && b_vfall < 0) b_vfall = k;
      if (!prev_b_vs && b_vsync && b_vrise < 0) b_vrise = k;
      prev_b_vs = b_vsync;
      if (b_frame_start) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (k == 7380) begin
        chk("coord_map", {8'd0, b_x, b_y, b_active, 6'd0},
            {8'd0, 9'd1, 8'd230, 1'b1, 6'd0});
        rgb_in = 3'b001;
      end
      if (k == 7381) begin
        chk("coord_rgb_next_step", b_rgb_out, 3'b001);
        rgb_in = 3'b110;
      end
    end
    pix_en = 1'b0;

    chk("hsync_first_fall", a_fall1, 658);
    chk("hsync_width", a_rise1 - a_fall1, 96);
    chk("line_period", a_fall2 - a_fall1, 800);
    chk("vsync_first_fall", b_vfall, 7842);
    chk("vsync_width", b_vrise - b_vfall, 32);
    chk("frame_start_first", fs1, 8400);
    chk("frame_start_period", fs2 - fs1, 8400);
    chk("frame_start_count", fs_cnt, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
